// File: rtl/board_click_mapper.sv
// Maps a cursor pixel position onto the gobang grid by repeated subtraction,
// tracks the hovered cell and raises a place request on each new in-board click.
module board_click_mapper #(
   parameter int         BOARD_X0   = 80,
   parameter int         BOARD_Y0   = 0,
   parameter int         CELL_W     = 32,
   parameter int         CELL_H     = 32,
   parameter int         GRID_N     = 15,
   parameter logic [7:0] CLICK_MASK = 8'h01
) (
   input  logic        clk,
   input  logic        rst_p,
   input  logic        valid_i,
   input  logic [11:0] x_i,
   input  logic [11:0] y_i,
   input  logic [7:0]  btn_i,
   input  logic        place_ready_i,
   output logic [3:0]  cell_x_o,
   output logic [3:0]  cell_y_o,
   output logic        in_board_o,
   output logic        place_valid_o,
   output logic        busy_o,
   output logic [7:0]  drop_cnt_o
);

   localparam logic [11:0] X0 = 12'(BOARD_X0);
   localparam logic [11:0] Y0 = 12'(BOARD_Y0);
   localparam logic [11:0] CW = 12'(CELL_W);
   localparam logic [11:0] CH = 12'(CELL_H);
   localparam logic [3:0]  GN = 4'(GRID_N);

   typedef enum logic [2:0] {IDLE, OFFS, DIV, RES, PLACE} state_t;

   state_t      state, state_nxt;
   logic [11:0] x_r, y_r, rx, ry;
   logic [7:0]  btn_r;
   logic [3:0]  qx, qy;
   logic        neg, click_prev;
   logic        neg_c, step_x, step_y, in_board_c, click_c, edge_c;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign busy_o = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst_p) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      neg_c      = (x_r < X0) || (y_r < Y0);
      step_x     = (rx >= CW) && (qx < GN);
      step_y     = (ry >= CH) && (qy < GN);
      in_board_c = !neg && (qx < GN) && (qy < GN);
      click_c    = |(btn_r & CLICK_MASK);
      edge_c     = click_c & ~click_prev;
      state_nxt  = state;
      case (state)
         IDLE:  if (valid_i) state_nxt = OFFS;
         OFFS:  state_nxt = neg_c ? RES : DIV;
         DIV:   if (!step_x && !step_y) state_nxt = RES;
         RES:   state_nxt = (edge_c && in_board_c) ? PLACE : IDLE;
         PLACE: if (place_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Working registers: sample latch, offset removal and the subtraction divider
   always_ff @(posedge clk) begin
      case (state)
         IDLE: if (valid_i) begin
            x_r   <= x_i;
            y_r   <= y_i;
            btn_r <= btn_i;
         end
         OFFS: begin
            neg <= neg_c;
            rx  <= x_r - X0;
            ry  <= y_r - Y0;
            qx  <= '0;
            qy  <= '0;
         end
         DIV: begin
            if (step_x) begin
               rx <= rx - CW;
               qx <= qx + 4'd1;
            end
            if (step_y) begin
               ry <= ry - CH;
               qy <= qy + 4'd1;
            end
         end
         default: ;
      endcase
   end

   // Visible outputs and click history
   always_ff @(posedge clk) begin
      if (rst_p) begin
         cell_x_o      <= '0;
         cell_y_o      <= '0;
         in_board_o    <= 1'b0;
         place_valid_o <= 1'b0;
         click_prev    <= 1'b0;
         drop_cnt_o    <= '0;
      end else begin
         if (valid_i && state != IDLE) drop_cnt_o <= sat_inc8(drop_cnt_o);
         if (state == RES) begin
            in_board_o    <= in_board_c;
            click_prev    <= click_c;
            place_valid_o <= edge_c && in_board_c;
            if (in_board_c) begin
               cell_x_o <= qx;
               cell_y_o <= qy;
            end
         end else if (state == PLACE && place_ready_i) begin
            place_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_board_click_mapper.sv
// Cycle-stepped bench for board_click_mapper: directed scenarios plus a random
// flood, compared every cycle against a transaction-level reference model.
module tb_board_click_mapper;

   localparam int         X0   = 80;
   localparam int         Y0   = 0;
   localparam int         CW   = 32;
   localparam int         CH   = 32;
   localparam int         GN   = 15;
   localparam logic [7:0] MASK = 8'h01;

   logic        clk = 1'b0;
   logic        rst_p = 1'b0;
   logic        valid_i = 1'b0;
   logic [11:0] x_i = '0;
   logic [11:0] y_i = '0;
   logic [7:0]  btn_i = '0;
   logic        place_ready_i = 1'b0;
   logic [3:0]  cell_x_o, cell_y_o;
   logic        in_board_o, place_valid_o, busy_o;
   logic [7:0]  drop_cnt_o;

   board_click_mapper #(
      .BOARD_X0(X0), .BOARD_Y0(Y0), .CELL_W(CW), .CELL_H(CH),
      .GRID_N(GN), .CLICK_MASK(MASK)
   ) dut (
      .clk(clk), .rst_p(rst_p), .valid_i(valid_i), .x_i(x_i), .y_i(y_i),
      .btn_i(btn_i), .place_ready_i(place_ready_i), .cell_x_o(cell_x_o),
      .cell_y_o(cell_y_o), .in_board_o(in_board_o), .place_valid_o(place_valid_o),
      .busy_o(busy_o), .drop_cnt_o(drop_cnt_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int e = 0;

   // Reference model: phase 0 idle, 1 computing (result due at p_edge), 2 request pending
   int   m_phase = 0;
   int   m_cx = 0, m_cy = 0, m_drop = 0;
   logic m_inb = 0, m_pv = 0, m_cp = 0;
   int   p_edge = 0, p_cx = 0, p_cy = 0;
   logic p_inb = 0, p_place = 0, p_cp = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s @cycle %0d: observed %0d expected %0d", tag, e, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic v, input int x, input int y,
                       input logic [7:0] b, input logic rdy);
      int   qx, qy, lat;
      logic neg, click;
      rst_p = r; valid_i = v; x_i = 12'(x); y_i = 12'(y); btn_i = b; place_ready_i = rdy;
      @(posedge clk);
      e++;
      if (r) begin
         m_phase = 0; m_cx = 0; m_cy = 0; m_inb = 0; m_pv = 0; m_cp = 0; m_drop = 0;
      end else begin
         if (v && m_phase != 0) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
         if (m_phase == 2) begin
            if (rdy) begin
               m_pv = 0;
               m_phase = 0;
            end
         end else if (m_phase == 1) begin
            if (e == p_edge) begin
               m_inb = p_inb;
               if (p_inb) begin
                  m_cx = p_cx;
                  m_cy = p_cy;
               end
               m_cp = p_cp;
               m_pv = p_place;
               m_phase = p_place ? 2 : 0;
            end
         end else if (v) begin
            neg = (x < X0) || (y < Y0);
            qx = neg ? 0 : (x - X0) / CW;
            qy = neg ? 0 : (y - Y0) / CH;
            if (qx > GN) qx = GN;
            if (qy > GN) qy = GN;
            lat = neg ? 2 : ((qx > qy) ? qx : qy) + 3;
            p_inb = !neg && (qx < GN) && (qy < GN);
            p_cx = qx;
            p_cy = qy;
            click = |(b & MASK);
            p_cp = click;
            p_place = click && !m_cp && p_inb;
            p_edge = e + lat;
            m_phase = 1;
         end
      end
      #1;
      rst_p = 1'b0;
      valid_i = 1'b0;
      check("cell_x", 32'(cell_x_o), 32'(m_cx));
      check("cell_y", 32'(cell_y_o), 32'(m_cy));
      check("in_board", 32'(in_board_o), 32'(m_inb));
      check("place_valid", 32'(place_valid_o), 32'(m_pv));
      check("busy", 32'(busy_o), 32'(m_phase != 0));
      check("drop_cnt", 32'(drop_cnt_o), 32'(m_drop));
   endtask

   task automatic idle(input int n, input logic rdy);
      repeat (n) step(1'b0, 1'b0, 0, 0, 8'h00, rdy);
   endtask

   initial begin
      // Reset
      step(1'b1, 1'b0, 0, 0, 8'h00, 1'b0);
      step(1'b1, 1'b0, 0, 0, 8'h00, 1'b0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_drop", 32'(drop_cnt_o), 32'd0);

      // Hover without click: cell (3,7), no request
      step(1'b0, 1'b1, 181, 255, 8'h00, 1'b0);
      idle(12, 1'b0);
      check("hover_cx", 32'(cell_x_o), 32'd3);
      check("hover_cy", 32'(cell_y_o), 32'd7);
      check("hover_inb", 32'(in_board_o), 32'd1);
      check("hover_pv", 32'(place_valid_o), 32'd0);

      // Click edge: request held while ready is low, then accepted
      step(1'b0, 1'b1, 181, 255, 8'h01, 1'b0);
      idle(15, 1'b0);
      check("place_pv", 32'(place_valid_o), 32'd1);
      check("place_cx", 32'(cell_x_o), 32'd3);
      check("place_cy", 32'(cell_y_o), 32'd7);
      step(1'b0, 1'b0, 0, 0, 8'h00, 1'b1);
      check("done_pv", 32'(place_valid_o), 32'd0);
      check("done_busy", 32'(busy_o), 32'd0);

      // Off-board click, then held click dragged back in
      step(1'b0, 1'b1, 50, 100, 8'h01, 1'b0);
      idle(4, 1'b0);
      check("off_inb", 32'(in_board_o), 32'd0);
      check("off_cx", 32'(cell_x_o), 32'd3);
      step(1'b0, 1'b1, 181, 255, 8'h01, 1'b0);
      idle(12, 1'b0);
      check("drag_pv", 32'(place_valid_o), 32'd0);
      check("drag_inb", 32'(in_board_o), 32'd1);

      // Grid edges
      step(1'b0, 1'b1, 560, 479, 8'h00, 1'b0);
      idle(20, 1'b0);
      check("edge15_inb", 32'(in_board_o), 32'd0);
      step(1'b0, 1'b1, 559, 479, 8'h00, 1'b0);
      idle(20, 1'b0);
      check("edge14_cx", 32'(cell_x_o), 32'd14);
      check("edge14_cy", 32'(cell_y_o), 32'd14);
      check("edge14_inb", 32'(in_board_o), 32'd1);

      // Reset while a request is pending
      step(1'b0, 1'b1, 100, 100, 8'h01, 1'b0);
      idle(8, 1'b0);
      check("pre_rst_pv", 32'(place_valid_o), 32'd1);
      step(1'b1, 1'b0, 0, 0, 8'h00, 1'b0);
      check("abort_pv", 32'(place_valid_o), 32'd0);
      check("abort_busy", 32'(busy_o), 32'd0);
      idle(2, 1'b0);

      // Random flood: valid every cycle
      for (int i = 0; i < 300; i++)
         step(1'b0, 1'b1, int'($urandom_range(80, 700)), int'($urandom_range(0, 600)),
              8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      idle(25, 1'b1);
      check("flood_sat", 32'(drop_cnt_o), 32'd255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
